// File: rtl/l1_cache_controller.sv
// l1_cache_controller: direct-mapped, write-back, write-allocate L1 cache controller.
// One request in flight. A request is accepted in IDLE only when exactly one of Pr_Rd / Pr_Wr
// is high. Lines move whole to and from memory over a simple req/ack handshake.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   Pr_Rd, Pr_Wr             processor read / write request
//   Address                  {tag, index, offset}
//   write_data               byte to write
//   read_done, write_done    one-cycle completion pulses
//   matrix_store             read data valid strobe (pulses with read_done)
//   output_data_to_processor read byte, held between reads
//   mem_rd, mem_wr           line fill / line write-back requests, held until mem_ack
//   mem_addr                 line address {tag, index}
//   mem_wdata, mem_rdata     victim line out, fill line in
//   mem_ack                  memory completion
//   hit_count, miss_count    saturating lookup counters (only with CACHE_STATS_EN)
//
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
module l1_cache_controller #(
  parameter int unsigned byte_size   = 8,
  parameter int unsigned Addr        = 37,
  parameter int unsigned no_of_sets  = 128,
  parameter int unsigned block_size  = 512,
  parameter int unsigned index_bits  = 7,
  parameter int unsigned tag_bits    = 24,
  parameter int unsigned offset_bits = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Pr_Rd,
  input  logic                          Pr_Wr,
  input  logic [Addr-1:0]               Address,
  input  logic [byte_size-1:0]          write_data,
  output logic                          read_done,
  output logic                          write_done,
  output logic [byte_size-1:0]          output_data_to_processor,
  output logic                          matrix_store,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [tag_bits+index_bits-1:0] mem_addr,
  output logic [block_size-1:0]         mem_wdata,
  input  logic [block_size-1:0]         mem_rdata,
  input  logic                          mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                   hit_count,
  output logic [15:0]                   miss_count
`endif
);

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StRespond} state_e;

  state_e                state_q, state_d;
  logic [Addr-1:0]       addr_q;
  logic [byte_size-1:0]  wdata_q;
  logic                  op_wr_q;
  logic [no_of_sets-1:0] valid_q, dirty_q;
  logic [tag_bits-1:0]   tag_q  [no_of_sets];
  logic [block_size-1:0] line_q [no_of_sets];
  logic                  read_done_q, write_done_q;
  logic [byte_size-1:0]  rdata_q;

  logic [tag_bits-1:0]           req_tag;
  logic [index_bits-1:0]         req_idx;
  logic [offset_bits-1:0]        req_off;
  logic [$clog2(block_size)-1:0] bit_sel;
  logic                          accept, hit;

  assign req_tag = addr_q[Addr-1 -: tag_bits];
  assign req_idx = addr_q[offset_bits +: index_bits];
  assign req_off = addr_q[offset_bits-1:0];
  assign bit_sel = {req_off, 3'b000};
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Hold off acceptance during the done pulse so the next request starts the cycle after it.
  assign accept = (state_q == StIdle) && ((Pr_Rd ^ Pr_Wr) == 1'b1) &&
                  !read_done_q && !write_done_q;

  always_comb begin
    state_d   = state_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: if (accept) state_d = StLookup;
      StLookup: begin
        if (hit)                   state_d = StRespond;
        else if (dirty_q[req_idx]) state_d = StWriteback;
        else                       state_d = StFill;
      end
      StWriteback: begin
        mem_wr    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx};
        mem_wdata = line_q[req_idx];
        if (mem_ack) state_d = StFill;
      end
      StFill: begin
        mem_rd   = 1'b1;
        mem_addr = {req_tag, req_idx};
        if (mem_ack) state_d = StRespond;
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_wr_q      <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      read_done_q  <= (state_q == StRespond) && !op_wr_q;
      write_done_q <= (state_q == StRespond) && op_wr_q;
      if (accept) begin
        addr_q  <= Address;
        wdata_q <= write_data;
        op_wr_q <= Pr_Wr;
      end
      if (state_q == StFill && mem_ack) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (state_q == StRespond) begin
        if (op_wr_q) dirty_q[req_idx] <= 1'b1;
        else         rdata_q <= line_q[req_idx][bit_sel +: byte_size];
      end
    end
  end

  // Tag and line storage carry no reset; valid_q gates their use.
  always_ff @(posedge CLK) begin
    if (state_q == StFill && mem_ack) begin
      line_q[req_idx] <= mem_rdata;
      tag_q[req_idx]  <= req_tag;
    end else if (state_q == StRespond && op_wr_q) begin
      line_q[req_idx][bit_sel +: byte_size] <= wdata_q;
    end
  end

  assign read_done                = read_done_q;
  assign write_done               = write_done_q;
  assign matrix_store             = read_done_q;
  assign output_data_to_processor = rdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit) begin
        if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      end else begin
        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_l1_cache_controller.sv
// Directed bench for l1_cache_controller: a vector table of requests with hand-computed
// outcomes, played against a small memory model that acks 3 cycles after each request,
// plus hand-written sequences for illegal requests, reset during FILL and data hold.
module tb_l1_cache_controller;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Pr_Rd, Pr_Wr;
  logic [36:0]  Address;
  logic [7:0]   write_data;
  logic         read_done, write_done, matrix_store, mem_rd, mem_wr, mem_ack;
  logic [7:0]   output_data_to_processor;
  logic [30:0]  mem_addr;
  logic [511:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  always #5 CLK = ~CLK;

  l1_cache_controller dut (
    .CLK                      (CLK),
    .RST                      (RST),
    .Pr_Rd                    (Pr_Rd),
    .Pr_Wr                    (Pr_Wr),
    .Address                  (Address),
    .write_data               (write_data),
    .read_done                (read_done),
    .write_done               (write_done),
    .output_data_to_processor (output_data_to_processor),
    .matrix_store             (matrix_store),
    .mem_rd                   (mem_rd),
    .mem_wr                   (mem_wr),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_rdata                (mem_rdata),
    .mem_ack                  (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count                (hit_count),
    .miss_count               (miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Results of the last do_req call.
  logic        r_done, r_rd, r_wr, r_ms, r_both, r_wb, r_fill, r_post;
  logic [30:0] r_wb_addr, r_fill_addr;
  logic [7:0]  r_wb_b0, r_data;
  int          r_cycles;

  // Issue one request and act as memory until a done pulse (bounded at 50 cycles).
  task automatic do_req(input logic wr, input logic [36:0] addr, input logic [7:0] wd,
                        input logic [7:0] base);
    logic [511:0] line;
    int wc, rc;
    for (int k = 0; k < 64; k++) line[8*k +: 8] = base + 8'(k);
    r_done = 0; r_rd = 0; r_wr = 0; r_ms = 0; r_both = 0; r_wb = 0; r_fill = 0;
    r_wb_addr = '0; r_fill_addr = '0; r_wb_b0 = '0; r_data = '0; r_cycles = 0;
    wc = 0; rc = 0;
    @(negedge CLK);
    Pr_Rd = !wr; Pr_Wr = wr; Address = addr; write_data = wd;
    @(posedge CLK);
    #1;
    // Scramble inputs: the request in flight must not see them.
    Pr_Rd = 0; Pr_Wr = 0; Address = ~addr; write_data = ~wd;
    for (int c = 1; c <= 50; c++) begin
      @(posedge CLK);
      #1;
      mem_ack = 0;
      if (mem_rd && mem_wr) r_both = 1;
      if (mem_wr) begin
        r_wb = 1; r_wb_addr = mem_addr; r_wb_b0 = mem_wdata[7:0];
        wc++;
        if (wc == 3) mem_ack = 1;
      end
      if (mem_rd) begin
        r_fill = 1; r_fill_addr = mem_addr; mem_rdata = line;
        rc++;
        if (rc == 3) mem_ack = 1;
      end
      if (read_done || write_done) begin
        r_done = 1; r_rd = read_done; r_wr = write_done; r_ms = matrix_store;
        r_data = output_data_to_processor; r_cycles = c;
        break;
      end
    end
    mem_ack = 0;
    @(posedge CLK);
    #1;
    r_post = read_done | write_done | matrix_store;
  endtask

  typedef struct packed {
    logic        wr;
    logic [23:0] tag;
    logic [6:0]  idx;
    logic [5:0]  off;
    logic [7:0]  wd;
    logic [7:0]  base;
    logic        exp_hit;
    logic        exp_wb;
    logic [30:0] exp_wb_addr;
    logic [7:0]  exp_wb_b0;
    logic [7:0]  exp_data;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  int   exp_hits, exp_misses;
  int   dones;
  logic saw_rd;

  initial begin
    vecs[0]  = '{1'b0, 24'h0,     7'd1,   6'd0,  8'h00, 8'h5A, 1'b0, 1'b0, 31'd0, 8'h00, 8'h5A};
    vecs[1]  = '{1'b1, 24'h0,     7'd1,   6'd0,  8'h11, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 24'h0,     7'd1,   6'd0,  8'h00, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'h11};
    vecs[3]  = '{1'b0, 24'h0,     7'd1,   6'd3,  8'h00, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'h5D};
    vecs[4]  = '{1'b1, 24'h0ABCDE, 7'd1,  6'd0,  8'h22, 8'h30, 1'b0, 1'b1, 31'd1, 8'h11, 8'h00};
    vecs[5]  = '{1'b0, 24'h0ABCDE, 7'd1,  6'd0,  8'h00, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'h22};
    vecs[6]  = '{1'b0, 24'h0ABCDE, 7'd1,  6'd9,  8'h00, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'h39};
    vecs[7]  = '{1'b0, 24'h0,     7'd1,   6'd0,  8'h00, 8'h70, 1'b0, 1'b1,
                 {24'h0ABCDE, 7'd1}, 8'h22, 8'h70};
    vecs[8]  = '{1'b0, 24'h5,     7'd127, 6'd63, 8'h00, 8'h01, 1'b0, 1'b0, 31'd0, 8'h00, 8'h40};
    vecs[9]  = '{1'b1, 24'h5,     7'd127, 6'd63, 8'hEE, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 24'h5,     7'd127, 6'd63, 8'h00, 8'h00, 1'b1, 1'b0, 31'd0, 8'h00, 8'hEE};

    RST = 1; Pr_Rd = 0; Pr_Wr = 0; Address = '0; write_data = '0; mem_ack = 0; mem_rdata = '0;
    #3 RST = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", {read_done, write_done, matrix_store, mem_rd, mem_wr}, 0);
    chk("reset_data", output_data_to_processor, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata[63:0], 0);
    @(negedge CLK) RST = 1;

    exp_hits = 0; exp_misses = 0;
    for (int i = 0; i < NV; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.exp_hit) exp_hits++; else exp_misses++;
      do_req(v.wr, {v.tag, v.idx, v.off}, v.wd, v.base);
      chk($sformatf("v%0d_done", i), r_done, 1);
      chk($sformatf("v%0d_kind", i), {r_rd, r_wr}, {!v.wr, v.wr});
      chk($sformatf("v%0d_strobe", i), r_ms, !v.wr);
      chk($sformatf("v%0d_one_pulse", i), r_post, 0);
      chk($sformatf("v%0d_rd_wr_excl", i), r_both, 0);
      chk($sformatf("v%0d_fill", i), r_fill, !v.exp_hit);
      chk($sformatf("v%0d_wb", i), r_wb, v.exp_wb);
      chk($sformatf("v%0d_latency", i), r_cycles, v.exp_hit ? 2 : (v.exp_wb ? 8 : 5));
      if (!v.exp_hit) chk($sformatf("v%0d_fill_addr", i), r_fill_addr, {v.tag, v.idx});
      if (v.exp_wb) begin
        chk($sformatf("v%0d_wb_addr", i), r_wb_addr, v.exp_wb_addr);
        chk($sformatf("v%0d_wb_byte0", i), r_wb_b0, v.exp_wb_b0);
      end
      if (!v.wr) chk($sformatf("v%0d_data", i), r_data, v.exp_data);
    end

    // Write hit must not disturb the last read byte.
    do_req(1'b1, {24'h5, 7'd127, 6'd0}, 8'h12, 8'h00);
    exp_hits++;
    chk("hold_done", r_wr, 1);
    chk("hold_data", output_data_to_processor, 8'hEE);

`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 16'(exp_hits));
    chk("miss_count", miss_count, 16'(exp_misses));
`endif

    // Both requests high for 5 cycles: nothing accepted.
    dones = 0; saw_rd = 0;
    @(negedge CLK);
    Pr_Rd = 1; Pr_Wr = 1; Address = {24'h77, 7'd3, 6'd0};
    repeat (5) begin
      @(posedge CLK);
      #1;
      if (read_done || write_done) dones++;
      if (mem_rd || mem_wr) saw_rd = 1;
    end
    Pr_Rd = 0; Pr_Wr = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (read_done || write_done) dones++;
      if (mem_rd || mem_wr) saw_rd = 1;
    end
    chk("both_no_done", dones, 0);
    chk("both_no_mem", saw_rd, 0);

    // Reset in the middle of FILL.
    @(negedge CLK);
    Pr_Rd = 1; Pr_Wr = 0; Address = {24'h9, 7'd2, 6'd0};
    @(posedge CLK);
    #1 Pr_Rd = 0;
    saw_rd = 0;
    for (int c = 0; c < 10 && !saw_rd; c++) begin
      @(posedge CLK);
      #1;
      if (mem_rd) saw_rd = 1;
    end
    chk("rst_fill_started", saw_rd, 1);
    #2 RST = 0;
    #1;
    chk("rst_mem_rd_drop", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge CLK) RST = 1;
    dones = 0;
    repeat (6) begin
      @(posedge CLK);
      #1;
      if (read_done || write_done || mem_rd) dones++;
    end
    chk("rst_abandoned", dones, 0);
    do_req(1'b0, {24'h9, 7'd2, 6'd0}, 8'h00, 8'hA0);
    chk("rst_reread_miss", r_fill, 1);
    chk("rst_reread_data", r_data, 8'hA0);
`ifdef CACHE_STATS_EN
    chk("rst_stats", {hit_count, miss_count}, {16'd0, 16'd1});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
